// File: rtl/wb_arb2.sv
// Two-master, one-slave Wishbone arbiter: round-robin grant held for the whole
// cyc tenure, combinational muxing from a registered owner, and an ack watchdog.
module wb_arb2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    // master 0 (data port)
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    // master 1 (instruction port)
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    // slave
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    output logic [1:0]      gnt_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q,  last_d;
    logic [1:0] gnt_q,   gnt_d;

    // Master inputs gathered into arrays so the owner mux is a simple index.
    logic [1:0]      m_cyc;
    logic [1:0]      m_stb;
    logic [1:0]      m_we;
    logic [AW-1:0]   m_adr [2];
    logic [DW-1:0]   m_dat [2];
    logic [DW/8-1:0] m_sel [2];
    logic [DW-1:0]   m_dat_out [2];
    logic [1:0]      m_ack_out;
    logic [1:0]      m_err_out;

    logic busy;
    logic own_cyc;
    logic wd_err;

    assign m_cyc    = {m1_cyc_i, m0_cyc_i};
    assign m_stb    = {m1_stb_i, m0_stb_i};
    assign m_we     = {m1_we_i,  m0_we_i};
    assign m_adr[0] = m0_adr_i;
    assign m_adr[1] = m1_adr_i;
    assign m_dat[0] = m0_dat_i;
    assign m_dat[1] = m1_dat_i;
    assign m_sel[0] = m0_sel_i;
    assign m_sel[1] = m1_sel_i;

    assign busy    = (state_q == ST_BUSY);
    assign own_cyc = m_cyc[owner_q];

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i || m1_cyc_i) begin
                    state_d = ST_BUSY;
                    // On a tie the master that was not served last wins.
                    owner_d = (m0_cyc_i && m1_cyc_i) ? ~last_q : m1_cyc_i;
                end
            end
            ST_BUSY: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        gnt_d = (state_d == ST_BUSY) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign s_cyc_o = busy & own_cyc;
    assign s_stb_o = busy & own_cyc & m_stb[owner_q];
    assign s_we_o  = busy & m_we[owner_q];
    assign s_adr_o = busy ? m_adr[owner_q] : '0;
    assign s_dat_o = busy ? m_dat[owner_q] : '0;
    assign s_sel_o = busy ? m_sel[owner_q] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mst
            logic is_owner;
            assign is_owner      = busy && (owner_q == 1'(gi));
            assign m_dat_out[gi] = is_owner ? s_dat_i : '0;
            assign m_ack_out[gi] = is_owner & s_ack_i;
            assign m_err_out[gi] = is_owner & wd_err;
        end
    endgenerate

    assign m0_dat_o = m_dat_out[0];
    assign m1_dat_o = m_dat_out[1];
    assign m0_ack_o = m_ack_out[0];
    assign m1_ack_o = m_ack_out[1];
    assign m0_err_o = m_err_out[0];
    assign m1_err_o = m_err_out[1];

    generate
        if (TIMEOUT > 0) begin : g_wd
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

            logic [CW-1:0] cnt_q, cnt_d;

            // Ack in the timeout cycle takes precedence over the forced err.
            assign wd_err = s_stb_o & ~s_ack_i & (cnt_q == CNT_MAX);

            always_comb begin
                cnt_d = cnt_q;
                if (!s_stb_o || s_ack_i || wd_err) begin
                    cnt_d = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end else begin : g_no_wd
            assign wd_err = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_wb_arb2.sv
// Directed bench for wb_arb2 (TIMEOUT=3): reset, single request, tie alternation,
// bus lock, watchdog err / ack-wins, stray ack and reset mid-transfer.
module tb_wb_arb2;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i;
    logic            m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0]   m0_adr_i;
    logic [DW-1:0]   m0_dat_i;
    logic [DW/8-1:0] m0_sel_i;
    logic [DW-1:0]   m0_dat_o;
    logic            m0_ack_o, m0_err_o;
    logic            m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0]   m1_adr_i;
    logic [DW-1:0]   m1_dat_i;
    logic [DW/8-1:0] m1_sel_i;
    logic [DW-1:0]   m1_dat_o;
    logic            m1_ack_o, m1_err_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [DW/8-1:0] s_sel_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i;
    logic [1:0]      gnt_o;

    int n_cmp = 0;
    int n_mis = 0;

    wb_arb2 #(.AW(AW), .DW(DW), .TIMEOUT(3)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h (t=%0t)", tag, got, $time);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge wb_clk_i);
    endtask

    initial begin
        wb_rst_i = 1'b1;
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
        s_dat_i = '0; s_ack_i = 0;

        // Reset: outputs stay 0 even with requests and slave activity present
        repeat (3) tick();
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h100; m1_sel_i = 4'hF;
        s_ack_i = 1; s_dat_i = 32'hFFFF_FFFF;
        mid();
        check_eq("rst_gnt", gnt_o, 2'b00);
        check_eq("rst_s_cyc", s_cyc_o, 0);
        check_eq("rst_s_adr", s_adr_o, 0);
        check_eq("rst_m1_ack", m1_ack_o, 0);
        check_eq("rst_m1_dat", m1_dat_o, 0);
        tick();
        mid();
        check_eq("rst_gnt_hold", gnt_o, 2'b00);

        // Single m1 read at 0x100, slave acks one cycle after grant
        tick(); wb_rst_i = 0; s_ack_i = 0; s_dat_i = '0;
        mid();
        check_eq("t1_gnt_latency", gnt_o, 2'b00);
        tick();
        mid();
        check_eq("t1_gnt", gnt_o, 2'b10);
        check_eq("t1_s_cyc", s_cyc_o, 1);
        check_eq("t1_s_stb", s_stb_o, 1);
        check_eq("t1_s_adr", s_adr_o, 32'h100);
        check_eq("t1_m1_ack_wait", m1_ack_o, 0);
        tick(); s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
        mid();
        check_eq("t1_m1_ack", m1_ack_o, 1);
        check_eq("t1_m1_dat", m1_dat_o, 32'hDEAD_BEEF);
        check_eq("t1_m1_err", m1_err_o, 0);
        check_eq("t1_m0_ack", m0_ack_o, 0);
        check_eq("t1_m0_dat", m0_dat_o, 0);
        tick(); s_ack_i = 0; s_dat_i = '0; m1_cyc_i = 0; m1_stb_i = 0;
        mid();
        check_eq("t1_drop_gnt", gnt_o, 2'b10);
        check_eq("t1_drop_s_cyc", s_cyc_o, 0);
        tick();
        mid();
        check_eq("t1_idle_gnt", gnt_o, 2'b00);

        // Tie: m0 first, m1 two cycles after m0 drops, then m0 again
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h10;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h20;
        mid();
        tick(); s_ack_i = 1; s_dat_i = 32'h1111_0000;
        mid();
        check_eq("t2_gnt_m0", gnt_o, 2'b01);
        check_eq("t2_s_adr", s_adr_o, 32'h10);
        check_eq("t2_m0_ack", m0_ack_o, 1);
        check_eq("t2_m1_ack", m1_ack_o, 0);
        check_eq("t2_m1_dat", m1_dat_o, 0);
        tick(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        mid();
        check_eq("t2_drop_gnt", gnt_o, 2'b01);
        tick();
        mid();
        check_eq("t2_dead_gnt", gnt_o, 2'b00);
        check_eq("t2_dead_s_cyc", s_cyc_o, 0);
        tick(); s_ack_i = 1; s_dat_i = 32'h2222_0000;
        mid();
        check_eq("t2_gnt_m1", gnt_o, 2'b10);
        check_eq("t2_s_adr_m1", s_adr_o, 32'h20);
        check_eq("t2_m1_ack2", m1_ack_o, 1);
        check_eq("t2_m1_dat2", m1_dat_o, 32'h2222_0000);
        tick(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        tick();
        mid();
        check_eq("t2_idle2", gnt_o, 2'b00);
        tick(); m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        tick(); s_ack_i = 1;
        mid();
        check_eq("t2_alt_gnt_m0", gnt_o, 2'b01);
        tick(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        tick();
        mid();
        check_eq("t2_idle3", gnt_o, 2'b00);

        // Bus lock: four m0 write beats while m1 waits
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF;
        m0_adr_i = 32'h40; m0_dat_i = 32'h1;
        tick();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 32'h300;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) tick();
            m0_adr_i = 32'h40 + 32'(4 * (i - 1));
            m0_dat_i = 32'(i);
            s_ack_i = 1;
            mid();
            check_eq($sformatf("t3_gnt_b%0d", i), gnt_o, 2'b01);
            check_eq($sformatf("t3_s_we_b%0d", i), s_we_o, 1);
            check_eq($sformatf("t3_s_sel_b%0d", i), s_sel_o, 4'hF);
            check_eq($sformatf("t3_s_adr_b%0d", i), s_adr_o, 32'h40 + 32'(4 * (i - 1)));
            check_eq($sformatf("t3_s_dat_b%0d", i), s_dat_o, 32'(i));
            check_eq($sformatf("t3_m0_ack_b%0d", i), m0_ack_o, 1);
            check_eq($sformatf("t3_m1_ack_b%0d", i), m1_ack_o, 0);
        end
        tick(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
        mid();
        check_eq("t3_drop_gnt", gnt_o, 2'b01);
        check_eq("t3_drop_m1_ack", m1_ack_o, 0);
        tick();
        mid();
        check_eq("t3_dead_gnt", gnt_o, 2'b00);
        tick(); s_ack_i = 1; s_dat_i = 32'h0000_CAFE;
        mid();
        check_eq("t3_gnt_m1", gnt_o, 2'b10);
        check_eq("t3_s_adr_m1", s_adr_o, 32'h300);
        check_eq("t3_s_we_m1", s_we_o, 0);
        check_eq("t3_m1_dat", m1_dat_o, 32'h0000_CAFE);
        tick(); s_ack_i = 0; s_dat_i = '0; m1_cyc_i = 0; m1_stb_i = 0;
        tick();

        // Watchdog: err on 4th unacked stb cycle, then ack wins on the next timeout
        tick(); m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h80; s_ack_i = 0;
        mid();
        check_eq("t4_gnt_latency", gnt_o, 2'b00);
        for (int c = 1; c <= 8; c++) begin
            tick();
            s_ack_i = (c == 8);
            mid();
            check_eq($sformatf("t4_err_c%0d", c), m0_err_o, (c == 4) ? 1 : 0);
            check_eq($sformatf("t4_ack_c%0d", c), m0_ack_o, (c == 8) ? 1 : 0);
            check_eq($sformatf("t4_m1_err_c%0d", c), m1_err_o, 0);
        end
        tick(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        tick(); s_ack_i = 1; s_dat_i = 32'h55;
        mid();
        check_eq("t5_stray_gnt", gnt_o, 2'b00);
        check_eq("t5_stray_m0_ack", m0_ack_o, 0);
        check_eq("t5_stray_m1_ack", m1_ack_o, 0);
        check_eq("t5_stray_m0_dat", m0_dat_o, 0);
        check_eq("t5_stray_s_cyc", s_cyc_o, 0);
        tick(); s_ack_i = 0; s_dat_i = '0;

        // Reset while m1 owns with stb pending
        tick(); m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h200;
        tick();
        mid();
        check_eq("t6_gnt_m1", gnt_o, 2'b10);
        tick(); wb_rst_i = 1;
        mid();
        check_eq("t6_sync_rst", gnt_o, 2'b10);
        tick();
        mid();
        check_eq("t6_rst_gnt", gnt_o, 2'b00);
        check_eq("t6_rst_s_cyc", s_cyc_o, 0);
        check_eq("t6_rst_m1_ack", m1_ack_o, 0);
        check_eq("t6_rst_m1_err", m1_err_o, 0);
        tick(); wb_rst_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        tick(); m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h44; m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        mid();
        check_eq("t6_tie_gnt_m0", gnt_o, 2'b01);
        check_eq("t6_tie_s_adr", s_adr_o, 32'h44);
        tick(); m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/wb_arb2.md
# wb_arb2

Two-master, one-slave Wishbone arbiter that lets the CPU instruction port and data port share a single slave path (for example one BRAM bridge) ahead of the crossbar. It provides round-robin grant and holds the bus for the whole `cyc` tenure. Signals are muxed combinationally from a registered grant. A watchdog terminates transfers the slave never acknowledges by returning `err` to the owning master.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 255, wait cycles before a forced `err`; 0 disables the watchdog

Ports:
- `wb_clk_i`  in  1  bus clock
- `wb_rst_i`  in  1  reset, synchronous, active-high
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  master 0 (data port) control
- `m0_adr_i`  in  AW  master 0 address
- `m0_dat_i`  in  DW  master 0 write data
- `m0_sel_i`  in  DW/8  master 0 byte select
- `m0_dat_o`  out  DW  master 0 read data
- `m0_ack_o`, `m0_err_o`  out  1 each  master 0 termination
- `m1_*`  same set as `m0_*`  master 1 (instruction port)
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  slave control
- `s_adr_o`  out  AW  slave address
- `s_dat_o`  out  DW  slave write data
- `s_sel_o`  out  DW/8  slave byte select
- `s_dat_i`  in  DW  slave read data
- `s_ack_i`  in  1  slave acknowledge
- `gnt_o`  out  2  registered one-hot grant (bit0 = m0, bit1 = m1); 00 = idle

## Operation
- **State:** `busy` (1 bit), `owner` (1 bit), `last` (1 bit, last master served), watchdog counter `cnt` of width clog2(TIMEOUT+1).
- **IDLE (`busy`=0):**
  - Only m0 has `cyc` → grant m0.
  - Only m1 has `cyc` → grant m1.
  - Both have `cyc` → grant the master ≠ `last`.
  - On grant: `busy`<=1, `owner`<=winner.
  - No `cyc` → remain idle.
- **BUSY:**
  - `s_*` outputs = owner's inputs.
  - `s_cyc_o` = owner `cyc`; `s_stb_o` = owner `cyc` & `stb`.
  - Owner `m*_dat_o` = `s_dat_i`, owner `ack` = `s_ack_i`.
  - The non-owner sees `dat_o`=0, `ack`=0, `err`=0 and waits. `stb` without `cyc` is ignored.
  - Owner drops `cyc` → `busy`<=0, `last`<=`owner`. Re-arbitration happens in the following IDLE cycle.
- **Idle outputs:** while not busy, every `s_*` output and every `m*_ack_o`/`m*_err_o`/`m*_dat_o` is 0.
- **Watchdog (TIMEOUT>0):**
  - `cnt` increments each cycle `s_stb_o`=1 and `s_ack_i`=0.
  - `cnt` clears on `s_ack_i`, on `s_stb_o`=0, or on err.
  - When `cnt`==TIMEOUT and `s_ack_i`=0, owner `err_o`=1 for that cycle. The master must treat err as a cycle termination.
  - `s_ack_i` and the timeout condition in the same cycle → ack wins, no err.
  - `cnt` saturates logic-wise; it never wraps past TIMEOUT.
- **Stray acks:** an ack arriving while not busy is discarded.
- **Reset mid-transfer:** grant is dropped immediately (next edge), `busy`=0, `cnt`=0, `last`=1. The slave transfer is abandoned with no ack or err issued.

## Timing
- **Reset values:**
  - All registers: `busy`=0, `owner`=0, `last`=1 (m0 wins the first tie), `cnt`=0, `gnt_o`=00.
  - All outputs 0.
- **Grant latency:** master raises `cyc` at edge N (bus idle) → `gnt_o` and `s_cyc_o` valid after edge N+1. This is 1 cycle of arbitration overhead.
- **Transfer path:** `s_ack_i` → owner `ack_o` and `s_dat_i` → owner `dat_o` are combinational, with zero added latency.
- **Handover:** owner drops `cyc` after edge K → idle during cycle K+1 → next owner is on the slave after edge K+2 (one dead cycle).
- **Back-to-back requests:** a master holding `cyc` across several `stb` beats keeps ownership for every beat (bus lock). The other master cannot preempt.
- **Watchdog timing:** err is asserted on the (TIMEOUT+1)-th consecutive cycle of unacknowledged `stb`.

## Test plan
- **Reset then single request:** hold `wb_rst_i`, then raise m1 `cyc`/`stb` read at adr 0x100 with slave acking 1 cycle later, data 0xDEADBEEF → `gnt_o`=10, m1 receives 0xDEADBEEF with ack, and all outputs read 0 during reset.
- **Simultaneous first request:** m0 and m1 raise `cyc` in the same cycle → m0 granted first. After m0 drops `cyc`, m1 is granted 2 cycles later. Repeat the tie → m0 is granted next (alternation).
- **Bus lock:** m0 issues 4 write beats (sel 0xF, data 0x1..0x4) holding `cyc` while m1 requests → the slave sees exactly the 4 m0 writes before any m1 access, and m1 gets no ack meanwhile.
- **Watchdog:** TIMEOUT=3, slave never acks an m0 read → m0 `err_o` high exactly on the 4th `stb` cycle, no `ack_o`, `cnt` back to 0. A second run with ack arriving in that same cycle → ack only, no err.
- **Reset mid-transfer:** assert `wb_rst_i` while m1 owns with `stb` pending → after the edge `gnt_o`=00 and `s_cyc_o`=0. A later tie after reset grants m0.
